countdown_timer: RTL and testbench

- Count-down counterpart to the up-counting stopwatch.
- Loads an hour/min/sec preset, decrements once per tick while running, stops at 00:00:00 and flags expiry.
- Shares the stopwatch's 12-hour range (hour 0..11, min/sec 0..59) so both can drive the same display path.
- Sits beside the stopwatch under the clock/timer top level.

---
 rtl/countdown_timer_pkg.sv | 35 +++
 rtl/countdown_timer_if.sv | 33 +++
 rtl/countdown_timer_tick_prescaler.sv | 38 +++
 rtl/countdown_timer.sv | 110 +++++++++++
 tb/tb_countdown_timer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer, also usable by the stopwatch:
// 12-hour HMS limits and widths, the timer state enum, and the preset clamp.
package countdown_timer_pkg;

  localparam int HOUR_W = 4;
  localparam int MS_W   = 6;

  localparam logic [HOUR_W-1:0] MAX_HOUR = 4'd11;
  localparam logic [MS_W-1:0]   MAX_MIN  = 6'd59;
  localparam logic [MS_W-1:0]   MAX_SEC  = 6'd59;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MS_W-1:0]   min;
    logic [MS_W-1:0]   sec;
  } hms_t;

  function automatic hms_t clamp_hms(input logic [HOUR_W-1:0] h,
                                     input logic [MS_W-1:0]   m,
                                     input logic [MS_W-1:0]   s);
    hms_t r;
    r.hour = (h > MAX_HOUR) ? MAX_HOUR : h;
    r.min  = (m > MAX_MIN)  ? MAX_MIN  : m;
    r.sec  = (s > MAX_SEC)  ? MAX_SEC  : s;
    return r;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control and status bundle for countdown_timer; state is a debug view of the FSM.
interface countdown_timer_if;
  import countdown_timer_pkg::*;

  // Handshake: there is no valid/ready pair. load/start/stop/clear are level
  // commands sampled on every rising clk edge (priority clear > load > stop >
  // start); status outputs are registered and change only on that edge.
  logic                load;
  logic [HOUR_W-1:0]   set_hour;
  logic [MS_W-1:0]     set_min;
  logic [MS_W-1:0]     set_sec;
  logic                start;
  logic                stop;
  logic                clear;
  logic [HOUR_W-1:0]   hour;
  logic [MS_W-1:0]     min;
  logic [MS_W-1:0]     sec;
  logic                running;
  logic                done;
  logic                expired;
  timer_state_t        state;

  modport master (
    output load, set_hour, set_min, set_sec, start, stop, clear,
    input  hour, min, sec, running, done, expired, state
  );

  modport slave (
    input  load, set_hour, set_min, set_sec, start, stop, clear,
    output hour, min, sec, running, done, expired, state
  );

endinterface

// File: rtl/countdown_timer_tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
module tick_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Holding the count while enable is low keeps the residue across a pause.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == LAST) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: loads an HMS preset, decrements once per tick in RUN, stops at zero.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload from the preset at zero instead of stopping.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic              clk,
  input  logic              reset,
  countdown_timer_if.slave  bus
);

  timer_state_t state_q, state_d;
  hms_t         cnt_q, cnt_d;
  hms_t         preset_q, preset_d;
  logic         done_q, done_d;

  hms_t         load_val;
  hms_t         dec_val;
  logic         cnt_zero;
  logic         load_ok;
  logic         pre_en;
  logic         pre_clr;
  logic         tick;

  assign load_val = clamp_hms(bus.set_hour, bus.set_min, bus.set_sec);
  assign cnt_zero = (cnt_q == '0);
  assign load_ok  = bus.load && (state_q != RUN);

  // Prescaler only advances on RUN cycles that are not overridden by clear/stop.
  assign pre_en  = (state_q == RUN) && !bus.clear && !bus.stop;
  assign pre_clr = bus.clear || load_ok ||
                   (bus.start && !bus.stop && (state_q == IDLE) && !cnt_zero);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (pre_en),
    .clr    (pre_clr),
    .tick   (tick)
  );

  always_comb begin
    dec_val = cnt_q;
    if (cnt_q.sec != '0) begin
      dec_val.sec = cnt_q.sec - MS_W'(1);
    end else begin
      dec_val.sec = MAX_SEC;
      if (cnt_q.min != '0) begin
        dec_val.min = cnt_q.min - MS_W'(1);
      end else begin
        dec_val.min  = MAX_MIN;
        dec_val.hour = cnt_q.hour - HOUR_W'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    preset_d = preset_q;
    done_d   = 1'b0;
    if (bus.clear) begin
      cnt_d   = '0;
      state_d = IDLE;
    end else if (load_ok) begin
      preset_d = load_val;
      cnt_d    = load_val;
      state_d  = IDLE;
    end else if (bus.stop) begin
      if (state_q == RUN) state_d = PAUSE;
    end else if (bus.start && (state_q inside {IDLE, PAUSE}) && !cnt_zero) begin
      state_d = RUN;
    end else if ((state_q == RUN) && tick) begin
      cnt_d = dec_val;
      if (dec_val == '0) begin
        done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        if (preset_q != '0) cnt_d   = preset_q;
        else                state_d = DONE;
`else
        state_d = DONE;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      preset_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      preset_q <= preset_d;
      done_q   <= done_d;
    end
  end

  assign bus.hour    = cnt_q.hour;
  assign bus.min     = cnt_q.min;
  assign bus.sec     = cnt_q.sec;
  assign bus.running = (state_q == RUN);
  assign bus.expired = (state_q == DONE);
  assign bus.done    = done_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICK_DIV=1 and auto-reload disabled.
module tb_countdown_timer;
  import countdown_timer_pkg::*;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  logic [MS_W-1:0] exp_q[$];

  countdown_timer_if tif ();

  countdown_timer #(.TICK_DIV(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (tif)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tif.load     = 1'b0;
    tif.start    = 1'b0;
    tif.stop     = 1'b0;
    tif.clear    = 1'b0;
    tif.set_hour = '0;
    tif.set_min  = '0;
    tif.set_sec  = '0;
  endtask

  task automatic do_load(input logic [3:0] h, input logic [5:0] m, input logic [5:0] s);
    tif.set_hour = h;
    tif.set_min  = m;
    tif.set_sec  = s;
    tif.load     = 1'b1;
    step();
    tif.load     = 1'b0;
  endtask

  task automatic do_start();
    tif.start = 1'b1;
    step();
    tif.start = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++;
    if ({tif.hour, tif.min, tif.sec} !== 16'h0) begin
      errors++; $display("FAIL reset_hms got=%0d:%0d:%0d exp=0:0:0", tif.hour, tif.min, tif.sec);
    end
    checks++;
    if ({tif.running, tif.done, tif.expired} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got=%b exp=000", {tif.running, tif.done, tif.expired});
    end
    checks++;
    if (tif.state !== IDLE) begin
      errors++; $display("FAIL reset_state got=%0d exp=%0d", tif.state, IDLE);
    end
  endtask

  task automatic test_countdown();
    logic [MS_W-1:0] e;
    do_load(4'd0, 6'd0, 6'd3);
    checks++;
    if (tif.sec !== 6'd3 || tif.state !== IDLE) begin
      errors++; $display("FAIL load3 got sec=%0d st=%0d exp sec=3 st=0", tif.sec, tif.state);
    end
    do_start();
    checks++;
    if (tif.sec !== 6'd3 || tif.running !== 1'b1 || tif.done !== 1'b0) begin
      errors++; $display("FAIL start3 got sec=%0d run=%b done=%b exp 3 1 0", tif.sec, tif.running, tif.done);
    end
    exp_q = {6'd2, 6'd1, 6'd0};
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (tif.sec !== e || tif.done !== (e == 6'd0)) begin
        errors++; $display("FAIL count_seq got sec=%0d done=%b exp sec=%0d done=%b", tif.sec, tif.done, e, (e == 6'd0));
      end
    end
    checks++;
    if (tif.expired !== 1'b1 || tif.running !== 1'b0 || tif.state !== DONE) begin
      errors++; $display("FAIL expiry got exp=%b run=%b st=%0d exp 1 0 3", tif.expired, tif.running, tif.state);
    end
    step();
    checks++;
    if (tif.done !== 1'b0 || tif.expired !== 1'b1 || tif.sec !== 6'd0) begin
      errors++; $display("FAIL done_pulse got done=%b exp=%b sec=%0d exp 0 1 0", tif.done, tif.expired, tif.sec);
    end
    do_start();
    checks++;
    if (tif.state !== DONE) begin
      errors++; $display("FAIL start_in_done got st=%0d exp=%0d", tif.state, DONE);
    end
  endtask

  task automatic test_borrow();
    do_load(4'd1, 6'd0, 6'd0);
    checks++;
    if (tif.expired !== 1'b0 || tif.hour !== 4'd1) begin
      errors++; $display("FAIL load_clears_exp got exp=%b hour=%0d exp 0 1", tif.expired, tif.hour);
    end
    do_start();
    step();
    checks++;
    if ({tif.hour, tif.min, tif.sec} !== {4'd0, 6'd59, 6'd59}) begin
      errors++; $display("FAIL borrow1 got=%0d:%0d:%0d exp=0:59:59", tif.hour, tif.min, tif.sec);
    end
    step();
    checks++;
    if ({tif.hour, tif.min, tif.sec} !== {4'd0, 6'd59, 6'd58}) begin
      errors++; $display("FAIL borrow2 got=%0d:%0d:%0d exp=0:59:58", tif.hour, tif.min, tif.sec);
    end
    tif.clear = 1'b1;
    step();
    tif.clear = 1'b0;
  endtask

  task automatic test_pause();
    int held;
    do_load(4'd0, 6'd0, 6'd9);
    do_start();
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (tif.sec !== 6'd5) begin
      errors++; $display("FAIL pre_stop got sec=%0d exp=5", tif.sec);
    end
    tif.stop = 1'b1;
    step();
    tif.stop = 1'b0;
    held = 1;
    for (int i = 0; i < 10; i++) begin
      if (tif.sec !== 6'd5 || tif.state !== PAUSE) held = 0;
      step();
    end
    checks++;
    if (held !== 1) begin
      errors++; $display("FAIL pause_hold got held=%0d exp=1", held);
    end
    do_start();
    checks++;
    if (tif.sec !== 6'd5 || tif.state !== RUN) begin
      errors++; $display("FAIL resume got sec=%0d st=%0d exp 5 1", tif.sec, tif.state);
    end
    step();
    checks++;
    if (tif.sec !== 6'd4) begin
      errors++; $display("FAIL resume_tick got sec=%0d exp=4", tif.sec);
    end
    do_load(4'd0, 6'd30, 6'd1);
    checks++;
    if ({tif.min, tif.sec} !== {6'd0, 6'd3} || tif.state !== RUN) begin
      errors++; $display("FAIL load_in_run got min=%0d sec=%0d st=%0d exp 0 3 1", tif.min, tif.sec, tif.state);
    end
  endtask

  task automatic test_clamp_clear();
    tif.clear = 1'b1;
    step();
    tif.clear = 1'b0;
    do_load(4'd13, 6'd60, 6'd63);
    checks++;
    if ({tif.hour, tif.min, tif.sec} !== {4'd11, 6'd59, 6'd59}) begin
      errors++; $display("FAIL clamp got=%0d:%0d:%0d exp=11:59:59", tif.hour, tif.min, tif.sec);
    end
    tif.clear = 1'b1;
    step();
    tif.clear = 1'b0;
    checks++;
    if ({tif.hour, tif.min, tif.sec} !== 16'h0 || tif.state !== IDLE) begin
      errors++; $display("FAIL clear got=%0d:%0d:%0d st=%0d exp=0:0:0 st=0", tif.hour, tif.min, tif.sec, tif.state);
    end
    do_start();
    checks++;
    if (tif.running !== 1'b0 || tif.state !== IDLE) begin
      errors++; $display("FAIL start_zero got run=%b st=%0d exp 0 0", tif.running, tif.state);
    end
  endtask

  task automatic test_start_stop_clear_run();
    int seen_done;
    do_load(4'd0, 6'd0, 6'd5);
    tif.start = 1'b1;
    tif.stop  = 1'b1;
    step();
    tif.start = 1'b0;
    tif.stop  = 1'b0;
    checks++;
    if (tif.state !== IDLE || tif.sec !== 6'd5) begin
      errors++; $display("FAIL start_stop got st=%0d sec=%0d exp 0 5", tif.state, tif.sec);
    end
    do_load(4'd0, 6'd0, 6'd9);
    do_start();
    step();
    step();
    checks++;
    if (tif.sec !== 6'd7) begin
      errors++; $display("FAIL pre_clear got sec=%0d exp=7", tif.sec);
    end
    tif.clear = 1'b1;
    step();
    tif.clear = 1'b0;
    seen_done = 0;
    checks++;
    if (tif.sec !== 6'd0 || tif.state !== IDLE) begin
      errors++; $display("FAIL clear_run got sec=%0d st=%0d exp 0 0", tif.sec, tif.state);
    end
    for (int i = 0; i < 5; i++) begin
      if (tif.done !== 1'b0) seen_done = 1;
      step();
    end
    checks++;
    if (seen_done !== 0) begin
      errors++; $display("FAIL clear_no_done got seen=%0d exp=0", seen_done);
    end
  endtask

  task automatic test_reset_mid_run();
    do_load(4'd2, 6'd0, 6'd9);
    do_start();
    step();
    reset = 1'b1;
    #3;
    checks++;
    if ({tif.hour, tif.sec} !== {4'd2, 6'd8} || tif.running !== 1'b1) begin
      errors++; $display("FAIL reset_sync got hour=%0d sec=%0d run=%b exp 2 8 1", tif.hour, tif.sec, tif.running);
    end
    step();
    reset = 1'b0;
    checks++;
    if ({tif.hour, tif.min, tif.sec} !== 16'h0 || tif.state !== IDLE || tif.expired !== 1'b0) begin
      errors++; $display("FAIL reset_run got=%0d:%0d:%0d st=%0d exp 0:0:0 st=0", tif.hour, tif.min, tif.sec, tif.state);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    idle_inputs();
    test_reset();
    test_countdown();
    test_borrow();
    test_pause();
    test_clamp_clear();
    test_start_stop_clear_run();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
